// File: rtl/bcd2bin_seq.sv
// bcd2bin_seq: sequential two-digit BCD to 6-bit binary converter (0..59).
// Reverse double-dabble, one shift-and-correct step per clock, start/done handshake.
// Optional build macro BCD2BIN_SAT_EN: illegal digits saturate binary to
// MAX_TENS*10+9 instead of 0 (err=1 in both builds).
module bcd2bin_seq #(
  parameter int MAX_TENS = 5,
  parameter int STEPS    = 7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] bcd_h,
  input  logic [3:0] bcd_l,
  output logic [5:0] binary,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  localparam logic [3:0] TENS_MAX  = 4'(MAX_TENS);
  localparam logic [2:0] LAST_STEP = 3'(STEPS - 1);
`ifdef BCD2BIN_SAT_EN
  localparam logic [5:0] ILLEGAL_VAL = 6'(MAX_TENS * 10 + 9);
`else
  localparam logic [5:0] ILLEGAL_VAL = '0;
`endif

  state_t      state, state_nx;
  logic [14:0] sreg;
  logic [14:0] sreg_step;
  logic [2:0]  cnt;
  logic        legal;

  // Digit legality, evaluated against the live inputs at capture time.
  always_comb begin
    legal = (bcd_l <= 4'd9) && (bcd_h <= TENS_MAX);
  end

  // One reverse double-dabble step: shift right, then correct each BCD nibble.
  always_comb begin
    sreg_step = sreg >> 1;
    if (sreg_step[14:11] >= 4'd8) sreg_step[14:11] = sreg_step[14:11] - 4'd3;
    if (sreg_step[10:7]  >= 4'd8) sreg_step[10:7]  = sreg_step[10:7]  - 4'd3;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nx = legal ? CONV : DONE;
      end
      CONV: begin
        busy = 1'b1;
        if (cnt == LAST_STEP) state_nx = DONE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Datapath: capture, step, and result/err update on entry to DONE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sreg   <= '0;
      cnt    <= '0;
      binary <= '0;
      err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (legal) begin
              sreg <= {bcd_h, bcd_l, 7'b0};
              cnt  <= '0;
              err  <= 1'b0;
            end else begin
              err    <= 1'b1;
              binary <= ILLEGAL_VAL;
            end
          end
        end
        CONV: begin
          sreg <= sreg_step;
          cnt  <= cnt + 3'd1;
          if (cnt == LAST_STEP) binary <= sreg_step[5:0];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd2bin_seq.sv
// tb_bcd2bin_seq: directed vector table plus hand-written multi-cycle sequences.
module tb_bcd2bin_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [3:0] bcd_h;
  logic [3:0] bcd_l;
  logic [5:0] binary;
  logic       busy;
  logic       done;
  logic       err;

  int vectors = 0;
  int miscompares = 0;

`ifdef BCD2BIN_SAT_EN
  localparam int ILL = 59;
`else
  localparam int ILL = 0;
`endif

  bcd2bin_seq #(.MAX_TENS(5), .STEPS(7)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bcd_h(bcd_h), .bcd_l(bcd_l),
    .binary(binary), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] h;
    logic [3:0] l;
    int         bin;
    int         e;
    int         lat;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Count edges until done is seen (sampled #1 after each edge), bounded.
  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 30) begin
      tick();
      n++;
    end
  endtask

  // Single conversion from IDLE: pulse start, check latency, result, and done dropping.
  task automatic convert(input logic [3:0] h, input logic [3:0] l,
                         input int exp_bin, input int exp_err, input int exp_lat);
    int n;
    bcd_h = h;
    bcd_l = l;
    start = 1'b1;
    tick();
    start = 1'b0;
    if (exp_lat > 0) chk("busy_after_capture", int'(busy), 1);
    wait_done(n);
    chk("latency", n, exp_lat);
    chk("done", int'(done), 1);
    chk("binary", int'(binary), exp_bin);
    chk("err", int'(err), exp_err);
    tick();
    chk("done_one_cycle", int'(done), 0);
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    start = 1'b0;
    bcd_h = '0;
    bcd_l = '0;
    tick();
    tick();
    chk("rst_binary", int'(binary), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    rst_n = 1'b1;
    tick();

    tbl[0] = '{4'h3, 4'h7, 37, 0, 7};
    tbl[1] = '{4'h5, 4'h9, 59, 0, 7};
    tbl[2] = '{4'h0, 4'h0, 0, 0, 7};
    tbl[3] = '{4'h2, 4'hA, ILL, 1, 0};
    tbl[4] = '{4'h6, 4'h0, ILL, 1, 0};
    tbl[5] = '{4'h0, 4'h9, 9, 0, 7};
    tbl[6] = '{4'h5, 4'h0, 50, 0, 7};
    tbl[7] = '{4'hF, 4'hF, ILL, 1, 0};
    tbl[8] = '{4'h5, 4'h9, 59, 0, 7};
    tbl[9] = '{4'h0, 4'hA, ILL, 1, 0};

    for (int i = 0; i < 10; i++)
      convert(tbl[i].h, tbl[i].l, tbl[i].bin, tbl[i].e, tbl[i].lat);

    // Full legal sweep.
    for (int t = 0; t < 6; t++)
      for (int u = 0; u < 10; u++)
        convert(4'(t), 4'(u), t * 10 + u, 0, 7);

    // start held high with 0x42: done every 9 cycles; change to 0x13 mid-CONV.
    bcd_h = 4'h4;
    bcd_l = 4'h2;
    start = 1'b1;
    wait_done(n);
    chk("held_first_lat", n, 8);
    chk("held_first_bin", int'(binary), 42);
    wait_done(n);
    if (n == 0) begin tick(); wait_done(n); n++; end
    chk("held_period", n, 9);
    chk("held_second_bin", int'(binary), 42);
    tick();
    tick();
    chk("held_busy_in_conv", int'(busy), 1);
    bcd_h = 4'h1;
    bcd_l = 4'h3;
    wait_done(n);
    chk("held_third_lat", n, 7);
    chk("held_third_bin", int'(binary), 42);
    tick();
    wait_done(n);
    chk("held_fourth_period", n + 1, 9);
    chk("held_fourth_bin", int'(binary), 13);
    start = 1'b0;
    tick();
    tick();

    // Reset in mid-conversion.
    bcd_h = 4'h4;
    bcd_l = 4'h5;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_binary", int'(binary), 0);
    chk("abort_err", int'(err), 0);
    n = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (done) n++;
    end
    chk("abort_no_done", n, 0);

    // Hold behaviour after 0x28.
    convert(4'h2, 4'h8, 28, 0, 7);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("hold_binary", int'(binary), 28);
      chk("hold_done", int'(done), 0);
      chk("hold_busy", int'(busy), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
